// File: rtl/c_drain_pkg.sv
// c_drain_pkg: shared types and constants for the C result drain.
// TAG_WIDTH is used only when C_DRAIN_TILE_TAG_EN is defined.
package c_drain_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        FLUSH = 2'd2
    } drain_state_t;

    localparam int TAG_WIDTH = 16;

    function automatic int addr_wth(input int a_part_w, input int b_num_w);
        return a_part_w + b_num_w;
    endfunction

endpackage

// File: rtl/c_result_drain_if.sv
// c_result_drain_if: valid/ready result stream toward writeback/DMA.
// The m_tag lane exists only when C_DRAIN_TILE_TAG_EN is defined.
interface c_result_drain_if #(
    parameter int D_WIDTH = 64
);
    logic               m_valid;
    logic               m_ready;
    logic [D_WIDTH-1:0] m_data;
    logic               m_last;
`ifdef C_DRAIN_TILE_TAG_EN
    logic [c_drain_pkg::TAG_WIDTH-1:0] m_tag;

    modport master (
        output m_valid, m_data, m_last, m_tag,
        input  m_ready
    );
    modport slave (
        input  m_valid, m_data, m_last, m_tag,
        output m_ready
    );
`else
    modport master (
        output m_valid, m_data, m_last,
        input  m_ready
    );
    modport slave (
        input  m_valid, m_data, m_last,
        output m_ready
    );
`endif
endinterface

// File: rtl/drain_fifo.sv
// drain_fifo: small synchronous FIFO with occupancy count.
// DEPTH must be a power of two; pointers wrap naturally.
module drain_fifo #(
    parameter int WIDTH = 65,
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push_in,
    input  logic [WIDTH-1:0]       wdata_in,
    input  logic                   pop_in,
    output logic [WIDTH-1:0]       rdata_out,
    output logic                   full_out,
    output logic                   empty_out,
    output logic [$clog2(DEPTH):0] count_out
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [AW-1:0]    wr_q, wr_d;
    logic [AW-1:0]    rd_q, rd_d;
    logic [AW:0]      cnt_q, cnt_d;

    always_comb begin
        mem_d = mem_q;
        wr_d  = wr_q;
        rd_d  = rd_q;
        cnt_d = cnt_q;
        if (push_in) begin
            mem_d[wr_q] = wdata_in;
            wr_d        = wr_q + AW'(1);
        end
        if (pop_in) begin
            rd_d = rd_q + AW'(1);
        end
        unique case ({push_in, pop_in})
            2'b10:   cnt_d = cnt_q + (AW+1)'(1);
            2'b01:   cnt_d = cnt_q - (AW+1)'(1);
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_q <= '{default: '0};
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            mem_q <= mem_d;
            wr_q  <= wr_d;
            rd_q  <= rd_d;
            cnt_q <= cnt_d;
        end
    end

    assign rdata_out = mem_q[rd_q];
    assign full_out  = (cnt_q == (AW+1)'(DEPTH));
    assign empty_out = (cnt_q == '0);
    assign count_out = cnt_q;

    a_no_overflow: assert property (
        @(posedge clk) disable iff (rst) !(push_in && full_out));
    a_no_underflow: assert property (
        @(posedge clk) disable iff (rst) !(pop_in && empty_out));

endmodule

// File: rtl/c_result_drain.sv
// c_result_drain: on each bank-swap trigger edge, read the finished bank
// and stream it out. Optional tile tag lane: define C_DRAIN_TILE_TAG_EN.
module c_result_drain
    import c_drain_pkg::*;
#(
    parameter int D_WIDTH      = 64,
    parameter int A_PART_WIDTH = 1,
    parameter int B_NUM_WIDTH  = 1,
    parameter int RD_LAT       = 2,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 trig_in,
    output logic                                 rd_en_out,
    output logic [A_PART_WIDTH+B_NUM_WIDTH-1:0]  rd_addr_out,
    input  logic [D_WIDTH-1:0]                   rd_data_in,
    c_result_drain_if.master                     m,
    output logic                                 busy_out,
    output logic                                 done_out,
    output logic                                 overrun_err_out
);
    localparam int ADDR_WTH = addr_wth(A_PART_WIDTH, B_NUM_WIDTH);
    localparam int CNT_W    = $clog2(FIFO_DEPTH) + 1;
    localparam int SUM_W    = CNT_W + 1;
    localparam logic [ADDR_WTH-1:0] LAST_ADDR = '1;

    // [0],[1] synchronize trig_in; [2] holds the previous synced level
    logic [2:0]          sync_q, sync_d;
    logic                pulse_q, pulse_d;
    drain_state_t        state_q, state_d;
    logic [ADDR_WTH-1:0] addr_q, addr_d;
    logic [RD_LAT-1:0]   sr_vld_q, sr_vld_d;
    logic [RD_LAT-1:0]   sr_last_q, sr_last_d;
    logic                ovr_q, ovr_d;
`ifdef C_DRAIN_TILE_TAG_EN
    logic [TAG_WIDTH-1:0] tag_q, tag_d;
`endif

    logic               fifo_push;
    logic               fifo_pop;
    logic               fifo_full;
    logic               fifo_empty;
    logic [CNT_W-1:0]   fifo_count;
    logic [D_WIDTH:0]   fifo_rdata;
    logic [SUM_W-1:0]   inflight;
    logic [SUM_W-1:0]   used;
    logic               issue;
    logic               done;

    always_comb begin
        sync_d    = {sync_q[1:0], trig_in};
        pulse_d   = sync_q[1] ^ sync_q[2];
        state_d   = state_q;
        addr_d    = addr_q;
        ovr_d     = ovr_q;
        inflight  = '0;
        for (int i = 0; i < RD_LAT; i++) begin
            inflight = inflight + SUM_W'(sr_vld_q[i]);
        end
        // Pops are ignored here, so a push can never meet a full FIFO
        used      = SUM_W'(fifo_count) + inflight;
        issue     = (state_q == READ) && !fifo_full
                    && (used < SUM_W'(FIFO_DEPTH));
        fifo_push = sr_vld_q[RD_LAT-1];
        fifo_pop  = !fifo_empty && m.m_ready;
        done      = (state_q == FLUSH) && fifo_pop
                    && fifo_rdata[D_WIDTH] && (inflight == '0);
        sr_vld_d[0]  = issue;
        sr_last_d[0] = issue && (addr_q == LAST_ADDR);
        for (int i = 1; i < RD_LAT; i++) begin
            sr_vld_d[i]  = sr_vld_q[i-1];
            sr_last_d[i] = sr_last_q[i-1];
        end
        if (pulse_q && (state_q != IDLE)) begin
            ovr_d = 1'b1;
        end
        unique case (state_q)
            IDLE: begin
                if (pulse_q) begin
                    addr_d  = '0;
                    state_d = READ;
                end
            end
            READ: begin
                if (issue) begin
                    if (addr_q == LAST_ADDR) begin
                        state_d = FLUSH;
                    end else begin
                        addr_d = addr_q + ADDR_WTH'(1);
                    end
                end
            end
            FLUSH: begin
                if (done) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
`ifdef C_DRAIN_TILE_TAG_EN
        tag_d = tag_q + TAG_WIDTH'(done);
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q    <= '0;
            pulse_q   <= 1'b0;
            state_q   <= IDLE;
            addr_q    <= '0;
            sr_vld_q  <= '0;
            sr_last_q <= '0;
            ovr_q     <= 1'b0;
`ifdef C_DRAIN_TILE_TAG_EN
            tag_q     <= '0;
`endif
        end else begin
            sync_q    <= sync_d;
            pulse_q   <= pulse_d;
            state_q   <= state_d;
            addr_q    <= addr_d;
            sr_vld_q  <= sr_vld_d;
            sr_last_q <= sr_last_d;
            ovr_q     <= ovr_d;
`ifdef C_DRAIN_TILE_TAG_EN
            tag_q     <= tag_d;
`endif
        end
    end

    drain_fifo #(
        .WIDTH (D_WIDTH + 1),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push_in   (fifo_push),
        .wdata_in  ({sr_last_q[RD_LAT-1], rd_data_in}),
        .pop_in    (fifo_pop),
        .rdata_out (fifo_rdata),
        .full_out  (fifo_full),
        .empty_out (fifo_empty),
        .count_out (fifo_count)
    );

    assign rd_en_out       = issue;
    assign rd_addr_out     = addr_q;
    assign m.m_valid       = !fifo_empty;
    assign m.m_data        = fifo_rdata[D_WIDTH-1:0];
    assign m.m_last        = fifo_rdata[D_WIDTH];
`ifdef C_DRAIN_TILE_TAG_EN
    assign m.m_tag         = tag_q;
`endif
    assign busy_out        = (state_q != IDLE);
    assign done_out        = done;
    assign overrun_err_out = ovr_q;

endmodule
